// File: rtl/program_counter.sv
// rtl/program_counter.sv - uPOWER fetch-stage program counter with next-PC logic (optional PC_ALIGN_CHECK_EN)
module program_counter #(
  parameter logic [63:0] RESET_PC    = 64'h0000_0000_0004_0000,
  parameter logic [63:0] INSTR_BYTES = 64'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        BranchEqual,
  input  logic        BranchNotEqual,
  input  logic        zero_flag,
  input  logic [63:0] immediate,
  output logic [63:0] PC,
  output logic [63:0] new_PC,
  output logic        branch_taken
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic        misaligned
`endif
);

  logic [63:0] pc_q;
  logic [63:0] pc_d;
  logic [63:0] seq_pc;
  logic [63:0] target_pc;
  logic        taken;

  // Branch decision and successor addresses; all arithmetic wraps modulo 2^64.
  always_comb begin
    taken     = (BranchEqual & zero_flag) | (BranchNotEqual & ~zero_flag);
    seq_pc    = pc_q + INSTR_BYTES;
    target_pc = pc_q + immediate;
`ifdef PC_ALIGN_CHECK_EN
    // A misaligned target is still taken, but snapped down to a word boundary.
    pc_d = taken ? {target_pc[63:2], 2'b00} : seq_pc;
`else
    pc_d = taken ? target_pc : seq_pc;
`endif
  end

  // PC register: reset wins over any pending branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC           = pc_q;
  assign new_PC       = pc_d;
  assign branch_taken = taken;

`ifdef PC_ALIGN_CHECK_EN
  // Flags a taken branch whose raw target is not word-aligned; quiet during reset.
  assign misaligned = ~rst & taken & (target_pc[1:0] != 2'b00);
`endif

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - directed self-checking bench for program_counter
module tb_program_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        BranchEqual;
  logic        BranchNotEqual;
  logic        zero_flag;
  logic [63:0] immediate;
  logic [63:0] PC;
  logic [63:0] new_PC;
  logic        branch_taken;
`ifdef PC_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  int n_cmp = 0;
  int n_err = 0;

  program_counter dut (
    .clk            (clk),
    .rst            (rst),
    .BranchEqual    (BranchEqual),
    .BranchNotEqual (BranchNotEqual),
    .zero_flag      (zero_flag),
    .immediate      (immediate),
    .PC             (PC),
    .new_PC         (new_PC),
    .branch_taken   (branch_taken)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misaligned     (misaligned)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic beq, input logic bne, input logic zf, input logic [63:0] imm);
    BranchEqual    = beq;
    BranchNotEqual = bne;
    zero_flag      = zf;
    immediate      = imm;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    step();
    step();
    check("reset_pc", PC, 64'h40000);
    check("reset_new_pc", new_PC, 64'h40004);
    check("reset_taken", {63'd0, branch_taken}, 64'd0);
`ifdef PC_ALIGN_CHECK_EN
    check("reset_misaligned", {63'd0, misaligned}, 64'd0);
`endif

    // Sequential fetch
    rst = 1'b0;
    step();
    check("seq_pc1", PC, 64'h40004);
    step();
    check("seq_pc2", PC, 64'h40008);
    step();
    check("seq_pc3", PC, 64'h4000C);

    // BNE backward by one word to return to 0x40008
    drive(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
    check("bne_back4_new", new_PC, 64'h40008);
    step();
    check("bne_back4_pc", PC, 64'h40008);

    // BEQ taken and not taken
    drive(1'b1, 1'b0, 1'b1, 64'd16);
    check("beq_taken_new", new_PC, 64'h40018);
    check("beq_taken_flag", {63'd0, branch_taken}, 64'd1);
    drive(1'b1, 1'b0, 1'b0, 64'd16);
    check("beq_not_new", new_PC, 64'h4000C);
    check("beq_not_flag", {63'd0, branch_taken}, 64'd0);
    step();
    check("beq_not_pc", PC, 64'h4000C);

    // Advance to 0x40010, then BNE backward by 8
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    step();
    check("seq_pc4", PC, 64'h40010);
    drive(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8);
    check("bne_back8_new", new_PC, 64'h40008);
    check("bne_back8_flag", {63'd0, branch_taken}, 64'd1);
    drive(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    check("bne_zf1_new", new_PC, 64'h40014);
    drive(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8);
    step();
    check("bne_back8_pc", PC, 64'h40008);

    // Both controls high: always taken
    drive(1'b1, 1'b1, 1'b1, 64'h20);
    check("both_zf1_new", new_PC, 64'h40028);
    drive(1'b1, 1'b1, 1'b0, 64'h20);
    check("both_zf0_new", new_PC, 64'h40028);
    check("both_zf0_flag", {63'd0, branch_taken}, 64'd1);

    // Self-loop with zero displacement
    drive(1'b1, 1'b0, 1'b1, 64'd0);
    step();
    check("self_loop_pc", PC, 64'h40008);

    // Jump to top of address space, then wrap
    drive(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFB_FFF4);
    check("jump_top_new", new_PC, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    check("jump_top_pc", PC, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    check("wrap_new", new_PC, 64'd0);
    step();
    check("wrap_pc", PC, 64'd0);

    // Mid-run reset overrides a taken branch
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 64'h100);
    step();
    check("midreset_pc", PC, 64'h40000);

    // Misaligned branch target
    drive(1'b1, 1'b0, 1'b1, 64'd6);
`ifdef PC_ALIGN_CHECK_EN
    check("misal_in_reset", {63'd0, misaligned}, 64'd0);
    rst = 1'b0;
    #1;
    check("misal_flag", {63'd0, misaligned}, 64'd1);
    check("misal_new", new_PC, 64'h40004);
    step();
    check("misal_pc", PC, 64'h40004);
`else
    rst = 1'b0;
    #1;
    check("odd_new", new_PC, 64'h40006);
    step();
    check("odd_pc", PC, 64'h40006);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
